bus_mcyc_ctrl: RTL and testbench

BUS_MCYC_CTRL -- requirements
Module: bus_mcyc_ctrl

---
 rtl/bus_mcyc_ctrl.sv | 147 ++++++++++++++
 tb/tb_bus_mcyc_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mcyc_ctrl.sv
// -----------------------------------------------------------------------------
// bus_mcyc_ctrl -- SM83 (Game Boy CPU) memory-bus M-cycle sequencer.
//
// Each M-cycle is four T-states (T1..T4, one per rising clk). The core places
// its request on req_* and it is latched on the edge leaving T4. That request
// then shapes the following M-cycle:
//   IDLE  : no strobes, address bus keeps its previous value
//   READ  : rd_n low T1..T3, din captured on the edge leaving T3
//   FETCH : READ plus m1 high for the whole cycle
//   WRITE : wr_n low T2..T3, dout driven (dout_en) T2..T4
// hold freezes every register, so sequencing resumes exactly where it stopped.
//
// Ports
//   clk        in   CPU clock, one T-state per rising edge
//   nreset     in   asynchronous active-low reset
//   hold       in   freeze T-state sequencing (HALT/STOP)
//   req_rd     in   read request for the next M-cycle
//   req_wr     in   write request for the next M-cycle (wins over req_rd)
//   req_fetch  in   read is an opcode fetch (only meaningful with req_rd)
//   req_adr    in   [15:0] address for the next M-cycle
//   req_dout   in   [7:0]  write data for the next M-cycle
//   din        in   [7:0]  data bus from memory
//   adr        out  [15:0] address bus
//   dout       out  [7:0]  write data bus
//   dout_en    out  data bus drive enable
//   rd_n/wr_n  out  active-low read/write strobes
//   tstate     out  [1:0]  current T-state, 0=T1 .. 3=T4
//   mcyc_start out  high during T1
//   m1         out  current M-cycle is an opcode fetch
//   rdata      out  [7:0]  last byte read
//   rdata_vld  out  one-clock pulse (T4) when rdata was just updated
// -----------------------------------------------------------------------------
module bus_mcyc_ctrl (
  input  logic        clk,
  input  logic        nreset,
  input  logic        hold,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        req_fetch,
  input  logic [15:0] req_adr,
  input  logic [7:0]  req_dout,
  input  logic [7:0]  din,
  output logic [15:0] adr,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        rd_n,
  output logic        wr_n,
  output logic [1:0]  tstate,
  output logic        mcyc_start,
  output logic        m1,
  output logic [7:0]  rdata,
  output logic        rdata_vld
);

  typedef enum logic [1:0] {
    KIND_IDLE  = 2'd0,
    KIND_READ  = 2'd1,
    KIND_FETCH = 2'd2,
    KIND_WRITE = 2'd3
  } kind_e;

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;

  kind_e       kind_q, kind_d;
  logic [1:0]  tstate_d;
  logic [15:0] adr_d;
  logic [7:0]  dout_d;
  logic [7:0]  rdata_d;
  logic        rdata_vld_d;
  logic        rd_n_d, wr_n_d, dout_en_d, m1_d, mcyc_start_d;
  logic        read_like_d;

  // Next-state and next-output logic. Strobes are decoded from the *next*
  // T-state and kind so every output comes straight from a flop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch to hold the old value.
    tstate_d    = tstate + 2'd1;
    kind_d      = kind_q;
    adr_d       = adr;
    dout_d      = dout;
    rdata_d     = rdata;
    rdata_vld_d = 1'b0;

    // Request latch point: the edge leaving T4 starts the next M-cycle.
    if (tstate == T4) begin
      if (req_wr) begin
        kind_d = KIND_WRITE;
      end else if (req_rd) begin
        kind_d = req_fetch ? KIND_FETCH : KIND_READ;
      end else begin
        kind_d = KIND_IDLE;
      end
      // IDLE cycles leave the address bus where it was.
      if (req_wr || req_rd) adr_d = req_adr;
      if (req_wr)           dout_d = req_dout;
    end

    // Memory data is taken on the edge leaving T3 of a read-type cycle.
    if (tstate == T3 && (kind_q == KIND_READ || kind_q == KIND_FETCH)) begin
      rdata_d     = din;
      rdata_vld_d = 1'b1;
    end

    read_like_d  = (kind_d == KIND_READ) || (kind_d == KIND_FETCH);
    rd_n_d       = !(read_like_d && (tstate_d != T4));
    wr_n_d       = !((kind_d == KIND_WRITE) && (tstate_d == T2 || tstate_d == T3));
    dout_en_d    = (kind_d == KIND_WRITE) && (tstate_d != T1);
    m1_d         = (kind_d == KIND_FETCH);
    mcyc_start_d = (tstate_d == T1);
  end

  // State register. hold simply withholds the update, freezing everything.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tstate     <= T1;
      kind_q     <= KIND_IDLE;
      adr        <= 16'h0000;
      dout       <= 8'h00;
      dout_en    <= 1'b0;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      m1         <= 1'b0;
      mcyc_start <= 1'b1;
      rdata      <= 8'h00;
      rdata_vld  <= 1'b0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values regardless of statement order.
      tstate     <= tstate_d;
      kind_q     <= kind_d;
      adr        <= adr_d;
      dout       <= dout_d;
      dout_en    <= dout_en_d;
      rd_n       <= rd_n_d;
      wr_n       <= wr_n_d;
      m1         <= m1_d;
      mcyc_start <= mcyc_start_d;
      rdata      <= rdata_d;
      rdata_vld  <= rdata_vld_d;
    end
  end

endmodule

// File: tb/tb_bus_mcyc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_mcyc_ctrl -- self-checking bench for bus_mcyc_ctrl.
// A table of M-cycle requests is applied at T4 boundaries (with random junk on
// req_* and din at all other edges); the expected four T-states of each cycle
// are queued when its request is driven and compared as they appear.
// Hand-written sequences cover hold and mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_bus_mcyc_ctrl;

  logic        clk = 1'b0;
  logic        nreset, hold, req_rd, req_wr, req_fetch;
  logic [15:0] req_adr;
  logic [7:0]  req_dout, din;
  logic [15:0] adr;
  logic [7:0]  dout, rdata;
  logic        dout_en, rd_n, wr_n, mcyc_start, m1, rdata_vld;
  logic [1:0]  tstate;

  always #5 clk = ~clk;

  bus_mcyc_ctrl dut (
    .clk        (clk),
    .nreset     (nreset),
    .hold       (hold),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_fetch  (req_fetch),
    .req_adr    (req_adr),
    .req_dout   (req_dout),
    .din        (din),
    .adr        (adr),
    .dout       (dout),
    .dout_en    (dout_en),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .tstate     (tstate),
    .mcyc_start (mcyc_start),
    .m1         (m1),
    .rdata      (rdata),
    .rdata_vld  (rdata_vld)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        fetch;
    logic [15:0] adr;
    logic [7:0]  wdata;
    logic [7:0]  din;
  } vec_t;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic        chk_dout;
    logic        dout_en;
    logic        rd_n;
    logic        wr_n;
    logic        m1;
    logic        mcyc_start;
    logic [7:0]  rdata;
    logic        rdata_vld;
  } exp_t;

  int errors = 0;
  int checks = 0;

  exp_t        sb[$];
  logic [15:0] m_adr;
  logic [7:0]  m_dout, m_rdata;
  int          t_cnt;
  logic [7:0]  cur_din, pend_din;
  vec_t        tbl[12];
  vec_t        idle_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic fetch,
                              input logic [15:0] a, input logic [7:0] wd, input logic [7:0] d);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fetch = fetch; v.adr = a; v.wdata = wd; v.din = d;
    return v;
  endfunction

  // Queue the expected four T-states of the cycle this request will start.
  task automatic push_cycle(input vec_t v);
    exp_t        e;
    logic        is_wr, is_rd, is_fetch;
    logic [15:0] new_adr;
    is_wr    = v.wr;
    is_rd    = !v.wr && v.rd;
    is_fetch = is_rd && v.fetch;
    new_adr  = (v.wr || v.rd) ? v.adr : m_adr;
    if (is_wr) m_dout = v.wdata;
    for (int t = 0; t < 4; t++) begin
      e.t          = 2'(t);
      e.adr        = new_adr;
      e.dout       = m_dout;
      e.chk_dout   = is_wr;
      e.dout_en    = is_wr && (t != 0);
      e.rd_n       = !(is_rd && (t != 3));
      e.wr_n       = !(is_wr && (t == 1 || t == 2));
      e.m1         = is_fetch;
      e.mcyc_start = (t == 0);
      e.rdata      = (is_rd && t == 3) ? v.din : m_rdata;
      e.rdata_vld  = is_rd && (t == 3);
      sb.push_back(e);
    end
    m_adr = new_adr;
    if (is_rd) m_rdata = v.din;
  endtask

  task automatic compare_top();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      check("tstate",     32'(tstate),     32'(e.t));
      check("adr",        32'(adr),        32'(e.adr));
      check("dout_en",    32'(dout_en),    32'(e.dout_en));
      check("rd_n",       32'(rd_n),       32'(e.rd_n));
      check("wr_n",       32'(wr_n),       32'(e.wr_n));
      check("m1",         32'(m1),         32'(e.m1));
      check("mcyc_start", 32'(mcyc_start), 32'(e.mcyc_start));
      check("rdata",      32'(rdata),      32'(e.rdata));
      check("rdata_vld",  32'(rdata_vld),  32'(e.rdata_vld));
      check("strobe_excl", 32'(rd_n | wr_n), 32'h1);
      if (e.chk_dout) check("dout", 32'(dout), 32'(e.dout));
    end
  endtask

  // One T-state: compare, drive the next edge's inputs, wait a clock.
  task automatic step(input vec_t nxt);
    compare_top();
    din = (t_cnt == 2) ? cur_din : 8'($urandom);
    if (t_cnt == 3) begin
      req_rd    = nxt.rd;
      req_wr    = nxt.wr;
      req_fetch = nxt.fetch;
      req_adr   = nxt.adr;
      req_dout  = nxt.wdata;
      push_cycle(nxt);
      pend_din  = nxt.din;
      t_cnt     = 0;
      cur_din   = pend_din;
    end else begin
      req_rd    = 1'($urandom);
      req_wr    = 1'($urandom);
      req_fetch = 1'($urandom);
      req_adr   = 16'($urandom);
      req_dout  = 8'($urandom);
      t_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic clear_req();
    req_rd = 1'b0; req_wr = 1'b0; req_fetch = 1'b0;
    req_adr = 16'h0000; req_dout = 8'h00;
  endtask

  // Reset, release on a falling edge; DUT then shows T1 of an IDLE cycle.
  task automatic do_reset();
    nreset = 1'b0;
    hold   = 1'b0;
    din    = 8'h00;
    clear_req();
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    sb.delete();
    m_adr = 16'h0000; m_dout = 8'h00; m_rdata = 8'h00;
    t_cnt = 0; cur_din = 8'h00; pend_din = 8'h00;
    push_cycle(idle_v);
  endtask

  initial begin
    idle_v = mk(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 16'h0100, 8'h00, 8'h3A); // fetch
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 16'hC000, 8'h00, 8'h5A); // read (HL)
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 16'hFF80, 8'hA5, 8'h00); // write wins over read
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 16'h1234, 8'h99, 8'h77); // idle, adr held
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 16'h2222, 8'h00, 8'h66); // fetch alone -> idle
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 16'h8000, 8'h3C, 8'h00); // write, fetch ignored
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00); // read top address
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 16'h0000, 8'h5F, 8'hEE); // all set -> write
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 16'h0101, 8'h00, 8'hFF); // fetch
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 16'h0002, 8'h00, 8'hC3); // read
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 16'h0003, 8'h00, 8'h00); // write 0x00
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'hABCD, 8'h00, 8'h00); // idle

    // Reset state while nreset is held low.
    nreset = 1'b0; hold = 1'b0; din = 8'h00; clear_req();
    @(negedge clk);
    check("rst_tstate",  32'(tstate),    32'h0);
    check("rst_adr",     32'(adr),       32'h0);
    check("rst_dout",    32'(dout),      32'h0);
    check("rst_dout_en", 32'(dout_en),   32'h0);
    check("rst_rd_n",    32'(rd_n),      32'h1);
    check("rst_wr_n",    32'(wr_n),      32'h1);
    check("rst_m1",      32'(m1),        32'h0);
    check("rst_rdata",   32'(rdata),     32'h0);
    check("rst_vld",     32'(rdata_vld), 32'h0);

    // Table-driven back-to-back cycles with off-boundary junk on req_*/din.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      repeat (4) step(tbl[i]);
    end
    repeat (8) step(idle_v);

    // Hold for 5 clocks entering T2 of a read.
    do_reset();
    repeat (3) @(negedge clk);
    req_rd = 1'b1; req_adr = 16'hC000;
    @(negedge clk);
    clear_req();
    check("hold_t1_rd_n", 32'(rd_n),   32'h0);
    check("hold_t1",      32'(tstate), 32'h0);
    @(negedge clk);
    check("hold_t2", 32'(tstate), 32'h1);
    hold = 1'b1; din = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_tstate", 32'(tstate),    32'h1);
      check("hold_rd_n",   32'(rd_n),      32'h0);
      check("hold_rdata",  32'(rdata),     32'h0);
      check("hold_vld",    32'(rdata_vld), 32'h0);
    end
    hold = 1'b0; din = 8'h5A;
    @(negedge clk);
    check("rel1_tstate", 32'(tstate),    32'h2);
    check("rel1_vld",    32'(rdata_vld), 32'h0);
    @(negedge clk);
    check("rel2_tstate", 32'(tstate),    32'h3);
    check("rel2_vld",    32'(rdata_vld), 32'h1);
    check("rel2_rdata",  32'(rdata),     32'h5A);
    check("rel2_adr",    32'(adr),       32'hC000);

    // Hold across the T3->T4 edge: din is taken on the first free edge only.
    req_rd = 1'b1; req_adr = 16'hC001;
    @(negedge clk);
    clear_req();
    check("h3_vld_drop", 32'(rdata_vld), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("h3_tstate", 32'(tstate), 32'h2);
    hold = 1'b1; din = 8'h11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("h3_hold_tstate", 32'(tstate),    32'h2);
      check("h3_hold_rdata",  32'(rdata),     32'h5A);
      check("h3_hold_vld",    32'(rdata_vld), 32'h0);
      check("h3_hold_rd_n",   32'(rd_n),      32'h0);
    end
    hold = 1'b0; din = 8'h3C;
    @(negedge clk);
    check("h3_rel_tstate", 32'(tstate),    32'h3);
    check("h3_rel_rdata",  32'(rdata),     32'h3C);
    check("h3_rel_vld",    32'(rdata_vld), 32'h1);
    check("h3_rel_adr",    32'(adr),       32'hC001);

    // Reset in T2 of a write aborts it at once; next cycle is IDLE.
    do_reset();
    repeat (3) @(negedge clk);
    req_wr = 1'b1; req_rd = 1'b1; req_adr = 16'hFF80; req_dout = 8'hA5;
    @(negedge clk);
    check("w_t1_wr_n", 32'(wr_n), 32'h1);
    check("w_t1_rd_n", 32'(rd_n), 32'h1);
    @(negedge clk);
    check("w_t2_wr_n",    32'(wr_n),    32'h0);
    check("w_t2_dout_en", 32'(dout_en), 32'h1);
    check("w_t2_dout",    32'(dout),    32'hA5);
    check("w_t2_adr",     32'(adr),     32'hFF80);
    #1 nreset = 1'b0;
    #1;
    check("ar_wr_n",    32'(wr_n),    32'h1);
    check("ar_rd_n",    32'(rd_n),    32'h1);
    check("ar_dout_en", 32'(dout_en), 32'h0);
    check("ar_tstate",  32'(tstate),  32'h0);
    @(negedge clk);
    check("ar_held_wr_n", 32'(wr_n), 32'h1);
    nreset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("post_rst_tstate",  32'(tstate),  32'(k));
      check("post_rst_wr_n",    32'(wr_n),    32'h1);
      check("post_rst_rd_n",    32'(rd_n),    32'h1);
      check("post_rst_dout_en", 32'(dout_en), 32'h0);
      @(negedge clk);
    end
    check("post_rst_w_t1_wr_n", 32'(wr_n), 32'h1);
    @(negedge clk);
    check("post_rst_w_t2_wr_n", 32'(wr_n), 32'h0);
    check("post_rst_w_t2_dout", 32'(dout), 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
